// File: rtl/inst_encoder_pkg.sv
// Shared types and opcodes for the RISC-V instruction encoder.
package inst_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_L   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_LUI = 3'd4
  } fmt_e;

  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the encoder.
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/inst_encoder_imm_pack.sv
// Combinational packer: scatters the immediate into the selected format and
// range-checks it so the decoder's immediate generator recovers it exactly.
module imm_pack
  import inst_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_range_ok
);

  logic w_fits12;
  logic w_fits13_even;
  logic w_fits_upper;

  // A value fits N signed bits when every bit above N-1 copies the sign bit.
  assign w_fits12      = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_fits13_even = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
  assign w_fits_upper  = ~(|i_imm[31:20]);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_inst     = '0;
    o_range_ok = 1'b0;
    case (i_fmt)
      FMT_I: begin
        o_inst     = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
        o_range_ok = w_fits12;
      end
      FMT_L: begin
        o_inst     = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_L};
        o_range_ok = w_fits12;
      end
      FMT_S: begin
        o_inst     = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_S};
        o_range_ok = w_fits12;
      end
      FMT_B: begin
        o_inst     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                      i_imm[4:1], i_imm[11], OP_B};
        o_range_ok = w_fits13_even;
      end
      FMT_LUI: begin
        o_inst     = {i_imm[19:0], i_rd, OP_LUI};
        o_range_ok = w_fits_upper;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: one-cycle registered output, word-address
// counter, and a RUN/FULL/FAULT controller gating the input stream.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  inst_encoder_if.slave bus,
  output logic          err,
  output logic          full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_out_valid;
  logic [31:0]       r_out_inst;
  logic [ADDR_W-1:0] r_out_addr;
  logic              w_in_ready;
  logic              w_accept;
  logic [31:0]       w_inst;
  logic              w_range_ok;

  imm_pack u_imm_pack (
    .i_fmt      (bus.in_fmt),
    .i_rd       (bus.in_rd),
    .i_rs1      (bus.in_rs1),
    .i_rs2      (bus.in_rs2),
    .i_funct3   (bus.in_funct3),
    .i_imm      (bus.in_imm),
    .o_inst     (w_inst),
    .o_range_ok (w_range_ok)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      RUN: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        if (bus.in_valid && w_in_ready) begin
          if (!w_range_ok)       w_state_nxt = FAULT;
          else if (r_idx == LAST) w_state_nxt = FULL;
        end
      end
      default: ;
    endcase
    if (clear) w_state_nxt = RUN;
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // clear wins over a same-cycle handshake and drops any pending word.
      if (clear) begin
        r_idx       <= '0;
        r_out_valid <= 1'b0;
      end else if (w_accept && w_range_ok) begin
        r_out_valid <= 1'b1;
        r_out_inst  <= w_inst;
        r_out_addr  <= ADDR_W'({r_idx, 2'b00});
        if (r_idx != LAST) r_idx <= r_idx + IDX_W'(1);
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_inst  = r_out_inst;
  assign bus.out_addr  = r_out_addr;
  assign err           = (r_state == FAULT);
  assign full          = (r_state == FULL);

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (DEPTH=4): encodings, range faults, clear,
// backpressure, fill-to-full, async reset and immediate round trip.
module tb_inst_encoder;
  import inst_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic err;
  logic full;
  int   n_cmp = 0;
  int   n_bad = 0;

  inst_encoder_if #(.ADDR_W(32)) bus ();

  inst_encoder #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .err   (err),
    .full  (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Independent decoder-side immediate generator.
  function automatic logic [31:0] imm_gen(input logic [31:0] inst);
    case (inst[6:0])
      OP_I, OP_L: return {{20{inst[31]}}, inst[31:20]};
      OP_S:       return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_B:       return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI:     return {12'd0, inst[31:12]};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    bus.in_fmt    = fmt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_imm    = imm;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    int waited = 0;
    set_fields(fmt, rd, rs1, rs2, f3, imm);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] inst, input logic [31:0] addr);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_inst"}, bus.out_inst, inst);
    check({tag, "_addr"}, bus.out_addr, addr);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [2:0] bnd_fmt [4] = '{FMT_B, FMT_B, FMT_S, FMT_I};
  int         bnd_imm [4] = '{4094, -4096, -2048, 2047};

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed encodings; DEPTH=4 so the fourth word after a clear fills memory.
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, -1);
    expect_word("enc_i", 32'hFFF0_0093, 32'd0);
    tick();
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    send(FMT_S, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    expect_word("enc_s", 32'h0020_A423, 32'd4);
    do_clear();
    send(FMT_B, 5'd0, 5'd1, 5'd2, 3'd0, -4);
    expect_word("enc_b", 32'hFE20_8EE3, 32'd0);
    send(FMT_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1_2345);
    expect_word("enc_lui", 32'h1234_52B7, 32'd4);
    send(FMT_I, 5'd3, 5'd4, 5'd0, 3'd0, 32'd2047);
    expect_word("enc_i_max", 32'h7FF2_0193, 32'd8);
    check("full_before", {31'd0, full}, 32'd0);
    send(FMT_L, 5'd6, 5'd2, 5'd0, 3'd2, -2048);
    expect_word("enc_l_min", 32'h8001_2303, 32'd12);
    check("full_set", {31'd0, full}, 32'd1);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("full_hold", {31'd0, full}, 32'd1);
    do_clear();
    check("full_cleared", {31'd0, full}, 32'd0);
    check("clear_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Range and format faults.
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    expect_word("pre_err", 32'h0050_0093, 32'd0);
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    check("err_i_range", {31'd0, err}, 32'd1);
    check("err_no_valid", {31'd0, bus.out_valid}, 32'd0);
    check("err_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("err_addr_kept", bus.out_addr, 32'd0);
    tick();
    check("err_sticky", {31'd0, err}, 32'd1);
    do_clear();
    check("err_cleared", {31'd0, err}, 32'd0);
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    expect_word("post_clear", 32'h0050_0093, 32'd0);
    send(FMT_B, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    check("err_b_odd", {31'd0, err}, 32'd1);
    do_clear();
    send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    check("err_fmt7", {31'd0, err}, 32'd1);
    do_clear();

    // Backpressure: one word pending and held, next bundle waits, none lost.
    bus.out_ready = 1'b0;
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    set_fields(FMT_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1_2345);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_hold_inst", bus.out_inst, 32'h0050_0093);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    expect_word("bp_next", 32'h1234_52B7, 32'd4);
    tick();
    check("bp_no_dup", {31'd0, bus.out_valid}, 32'd0);

    // Round trip: boundary table first, then random legal bundles.
    for (int b = 0; b < 3; b++) begin
      do_clear();
      for (int k = 0; k < 4; k++) begin
        logic [2:0] f;
        int v;
        if (b == 0) begin
          f = bnd_fmt[k];
          v = bnd_imm[k];
        end else begin
          f = 3'($urandom_range(4));
          case (f)
            FMT_B:   v = (int'($urandom_range(4095)) - 2048) * 2;
            FMT_LUI: v = int'($urandom_range(20'hF_FFFF));
            default: v = int'($urandom_range(4095)) - 2048;
          endcase
        end
        send(f, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
             3'($urandom_range(7)), v);
        check("rt_imm", imm_gen(bus.out_inst), v);
        check("rt_addr", bus.out_addr, 32'(k * 4));
      end
    end

    // Asynchronous reset while the third word is pending.
    do_clear();
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send(FMT_I, 5'd2, 5'd0, 5'd0, 3'd0, 32'd6);
    set_fields(FMT_I, 5'd3, 5'd0, 5'd0, 3'd0, 32'd7);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    bus.in_valid = 1'b0;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_out_inst", bus.out_inst, 32'd0);
    check("arst_out_addr", bus.out_addr, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    check("arst_full", {31'd0, full}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    send(FMT_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    expect_word("arst_restart", 32'h0050_0093, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
